apb_timer_sched: RTL and testbench

APB_TIMER_SCHED -- requirements
Module: apb_timer_sched

---
 rtl/apb_timer_sched.sv | 193 +++++++++++++++++++
 tb/tb_apb_timer_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_sched.sv
// Shares the low timer channel between NUM_REQ requesters, one job at a time:
// round-robin pick, then APB writes to arm the one-shot timer, wait for irq, disarm.
module apb_timer_sched #(
  parameter int unsigned                NUM_REQ        = 4,
  parameter int unsigned                APB_ADDR_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0]  TIMER_BASE     = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [32*NUM_REQ-1:0]       req_cmp_i,
  input  logic [8*NUM_REQ-1:0]        req_presc_i,
  output logic [NUM_REQ-1:0]          done_o,
  output logic                        err_o,
  output logic                        busy_o,
  output logic [APB_ADDR_WIDTH-1:0]   PADDR_o,
  output logic [31:0]                 PWDATA_o,
  output logic                        PWRITE_o,
  output logic                        PSEL_o,
  output logic                        PENABLE_o,
  input  logic [31:0]                 PRDATA_i,
  input  logic                        PREADY_i,
  input  logic                        PSLVERR_i,
  input  logic                        irq_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CFG_LO = TIMER_BASE;
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CMP_LO = TIMER_BASE + APB_ADDR_WIDTH'(16);

  typedef enum logic [2:0] {IDLE, W_RST, W_CMP, W_EN, WAIT_IRQ, W_OFF, DONE} state_t;
  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

  state_t            state_reg, state_next;
  phase_t            phase_reg, phase_next;
  logic [IDX_W-1:0]  owner_reg, owner_next;
  logic [IDX_W-1:0]  last_reg, last_next;
  logic [31:0]       cmp_reg, cmp_next;
  logic [7:0]        presc_reg, presc_next;
  logic              err_reg, err_next;

  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand;
  logic [31:0]       sel_cmp;
  logic [7:0]        sel_presc;
  logic [APB_ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              in_write;

  logic unused_prdata;
  assign unused_prdata = ^PRDATA_i;

  // Round-robin search begins one past the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_reg) + k) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_cmp   = '0;
    sel_presc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_cmp   = req_cmp_i[32*i +: 32];
        sel_presc = req_presc_i[8*i +: 8];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_ready_o[gi] = rst_ni && (state_reg == IDLE) && grant_found &&
                             (grant_idx == IDX_W'(gi));
    assign done_o[gi]      = (state_reg == DONE) && (owner_reg == IDX_W'(gi));
  end

  assign busy_o = (state_reg != IDLE);
  assign err_o  = (state_reg == DONE) && err_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      phase_reg <= PH_GAP;
      owner_reg <= '0;
      last_reg  <= IDX_W'(NUM_REQ - 1);
      cmp_reg   <= '0;
      presc_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      cmp_reg   <= cmp_next;
      presc_reg <= presc_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cmp_next   = cmp_reg;
    presc_next = presc_reg;
    err_next   = err_reg;
    wr_addr    = ADDR_CFG_LO;
    wr_data    = '0;
    in_write   = 1'b0;
    PSEL_o     = 1'b0;
    PENABLE_o  = 1'b0;
    PWRITE_o   = 1'b0;
    PADDR_o    = '0;
    PWDATA_o   = '0;

    case (state_reg)
      W_RST: wr_data = 32'h0000_0002;
      W_CMP: begin
        wr_addr = ADDR_CMP_LO;
        wr_data = cmp_reg;
      end
      W_EN:  wr_data = {16'h0000, presc_reg, 1'b0, |presc_reg, 6'h35};
      default: wr_data = '0;
    endcase

    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          state_next = W_RST;
          phase_next = PH_SETUP;
          owner_next = grant_idx;
          last_next  = grant_idx;
          cmp_next   = sel_cmp;
          presc_next = sel_presc;
          err_next   = 1'b0;
        end
      end
      W_RST, W_CMP, W_EN, W_OFF: begin
        in_write  = 1'b1;
        PSEL_o    = (phase_reg != PH_GAP);
        PENABLE_o = (phase_reg == PH_ACCESS);
        PWRITE_o  = (phase_reg != PH_GAP);
        if (phase_reg != PH_GAP) begin
          PADDR_o  = wr_addr;
          PWDATA_o = wr_data;
        end
        case (phase_reg)
          PH_GAP:   phase_next = PH_SETUP;
          PH_SETUP: phase_next = PH_ACCESS;
          default: begin
            if (PREADY_i) begin
              // Every transfer after the first is preceded by one idle bus cycle.
              phase_next = PH_GAP;
              if (state_reg == W_OFF) begin
                err_next   = err_reg | PSLVERR_i;
                state_next = DONE;
              end else if (PSLVERR_i) begin
                err_next   = 1'b1;
                state_next = W_OFF;
              end else begin
                case (state_reg)
                  W_RST:   state_next = W_CMP;
                  W_CMP:   state_next = W_EN;
                  default: state_next = WAIT_IRQ;
                endcase
              end
            end
          end
        endcase
      end
      WAIT_IRQ: begin
        // The bus already idles here, so the disarm write may start at once.
        if (irq_i) begin
          state_next = W_OFF;
          phase_next = PH_SETUP;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_timer_sched.sv
// Directed bench for apb_timer_sched: APB completer model with wait-state and
// error injection, write log, and step-by-step checks of each job.
module tb_apb_timer_sched;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_cmp = '0;
  logic [31:0]  req_presc = '0;
  logic [3:0]   done;
  logic         err;
  logic         busy;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic         pwrite;
  logic         psel;
  logic         penable;
  logic [31:0]  prdata;
  logic         pready;
  logic         pslverr;
  logic         irq = 1'b0;

  int           ws_target = 0;
  int           ws_seen = 0;
  logic         err_en = 1'b0;
  logic [31:0]  err_addr = '0;
  logic [31:0]  err_data = '0;
  logic [63:0]  wr_q[$];

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  always #5 clk = ~clk;

  apb_timer_sched #(
    .NUM_REQ(4),
    .APB_ADDR_WIDTH(32),
    .TIMER_BASE(32'h0)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_cmp_i(req_cmp),
    .req_presc_i(req_presc),
    .done_o(done),
    .err_o(err),
    .busy_o(busy),
    .PADDR_o(paddr),
    .PWDATA_o(pwdata),
    .PWRITE_o(pwrite),
    .PSEL_o(psel),
    .PENABLE_o(penable),
    .PRDATA_i(prdata),
    .PREADY_i(pready),
    .PSLVERR_i(pslverr),
    .irq_i(irq)
  );

  // Completer: wait states only on CMP_LO, error on a chosen address/data pair.
  assign prdata  = 32'h0;
  assign pready  = !(psel && penable && paddr == 32'h10 && ws_seen < ws_target);
  assign pslverr = err_en && psel && penable && paddr == err_addr && pwdata == err_data;

  always @(posedge clk) begin
    if (psel && penable && !pready) ws_seen <= ws_seen + 1;
    else if (!psel) ws_seen <= 0;
    if (psel && penable && pready) wr_q.push_back({paddr, pwdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input int idx, input logic [31:0] a, input logic [31:0] d,
                          input string tag);
    logic [63:0] obs;
    obs = (idx < wr_q.size()) ? wr_q[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
    chk(tag, obs, {a, d});
  endtask

  task automatic start_job(input int idx, input logic [31:0] cmp, input logic [7:0] presc,
                           input string tag);
    req_cmp[idx*32 +: 32]  = cmp;
    req_presc[idx*8 +: 8]  = presc;
    req_valid = 4'b0001 << idx;
    #1;
    chk({tag, "_ready"}, req_ready, 4'b0001 << idx);
    @(negedge clk);
    req_valid = '0;
    chk({tag, "_setup_ctl"}, {psel, penable, pwrite, busy, req_ready}, 8'hB0);
    chk({tag, "_setup_ad"}, {paddr, pwdata}, {32'h0, 32'h2});
  endtask

  task automatic wait_writes(input int n, input string tag);
    int c = 0;
    while (wr_q.size() < n && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_nwr"}, wr_q.size(), n);
  endtask

  task automatic wait_done(input logic [3:0] exp_done, input logic exp_err, input string tag);
    int c = 0;
    while (done == 4'b0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, err, exp_err);
    $display("job %s: done=%b err=%b after %0d cycles", tag, done, err, c);
    @(negedge clk);
    chk({tag, "_pulse1"}, {done, err, busy}, 6'b0);
  endtask

  initial begin
    int         base;
    int         c;
    int         acc;
    int         ng;
    logic       stable;
    logic [3:0] grants [5];

    // Reset: outputs quiet even with every requester asking.
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {req_ready, done, err, busy, psel, penable, pwrite}, 0);
    chk("rst_bus", {paddr, pwdata}, 0);
    rst_ni = 1'b1;
    req_valid = '0;
    @(negedge clk);

    // Single job, prescaler off.
    base = wr_q.size();
    start_job(2, 32'd100, 8'h00, "t1");
    wait_writes(base + 3, "t1");
    check_wr(base + 0, 32'h00, 32'h2, "t1_wr_rst");
    check_wr(base + 1, 32'h10, 32'd100, "t1_wr_cmp");
    check_wr(base + 2, 32'h00, 32'h35, "t1_wr_en");
    repeat (101) @(negedge clk);
    chk("t1_wait_irq", {wr_q.size() == base + 3, busy, psel}, 3'b110);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    wait_done(4'b0100, 1'b0, "t1");
    check_wr(base + 3, 32'h00, 32'h0, "t1_wr_off");

    // Prescaler enabled.
    base = wr_q.size();
    start_job(1, 32'd5, 8'h0A, "t2");
    wait_writes(base + 3, "t2");
    check_wr(base + 1, 32'h10, 32'd5, "t2_wr_cmp");
    check_wr(base + 2, 32'h00, 32'h0000_0A75, "t2_wr_en");
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    wait_done(4'b0010, 1'b0, "t2");
    check_wr(base + 3, 32'h00, 32'h0, "t2_wr_off");

    // Three wait states on the CMP_LO write.
    base = wr_q.size();
    ws_target = 3;
    start_job(0, 32'h1234, 8'h00, "ws");
    c = 0;
    while (!(psel && paddr == 32'h10) && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("ws_cmp_ctl", {psel, penable}, 2'b10);
    chk("ws_cmp_ad", {paddr, pwdata}, {32'h10, 32'h1234});
    acc = 0;
    stable = 1'b1;
    @(negedge clk);
    while (psel && penable && acc < 10) begin
      acc++;
      if ({paddr, pwdata} != {32'h10, 32'h1234}) stable = 1'b0;
      @(negedge clk);
    end
    chk("ws_access_len", acc, 4);
    chk("ws_stable", stable, 1'b1);
    chk("ws_gap", {psel, penable}, 2'b00);
    @(negedge clk);
    chk("ws_en_ctl", {psel, penable}, 2'b10);
    chk("ws_en_ad", {paddr, pwdata}, {32'h0, 32'h35});
    ws_target = 0;
    wait_writes(base + 3, "ws");
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    wait_done(4'b0001, 1'b0, "ws");

    // Slave error on the CMP_LO write: skip enable, still disarm.
    base = wr_q.size();
    err_en = 1'b1;
    err_addr = 32'h10;
    err_data = 32'd7;
    start_job(2, 32'd7, 8'h00, "e1");
    wait_done(4'b0100, 1'b1, "e1");
    chk("e1_nwr", wr_q.size(), base + 3);
    check_wr(base + 2, 32'h00, 32'h0, "e1_wr_off");
    err_en = 1'b0;

    // Slave error on the disarm write; irq held high is ignored until WAIT_IRQ.
    base = wr_q.size();
    err_en = 1'b1;
    err_addr = 32'h0;
    err_data = 32'h0;
    irq = 1'b1;
    start_job(0, 32'd3, 8'h01, "e2");
    wait_done(4'b0001, 1'b1, "e2");
    chk("e2_nwr", wr_q.size(), base + 4);
    check_wr(base + 2, 32'h00, 32'h175, "e2_wr_en");
    check_wr(base + 3, 32'h00, 32'h0, "e2_wr_off");
    err_en = 1'b0;

    // Next job reports no error; compare value 0 passes through.
    base = wr_q.size();
    start_job(3, 32'd0, 8'h00, "e3");
    wait_done(4'b1000, 1'b0, "e3");
    check_wr(base + 1, 32'h10, 32'h0, "e3_wr_cmp");
    irq = 1'b0;

    // Reset while waiting for irq.
    base = wr_q.size();
    start_job(1, 32'd50, 8'h00, "rs");
    wait_writes(base + 3, "rs");
    repeat (3) @(negedge clk);
    chk("rs_busy", busy, 1'b1);
    rst_ni = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("rs_ctrl", {req_ready, done, err, busy, psel, penable, pwrite}, 0);
    chk("rs_bus", {paddr, pwdata}, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    req_valid = 4'b1000;
    req_cmp[96 +: 32] = 32'd9;
    #1;
    chk("rs_ready3", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    chk("rs_setup", {psel, penable, paddr, pwdata}, {2'b10, 32'h0, 32'h2});
    chk("rs_no_cleanup", wr_q.size(), base + 3);
    irq = 1'b1;
    wait_done(4'b1000, 1'b0, "rs");

    // Fairness with every requester asking continuously.
    req_valid = 4'hF;
    ng = 0;
    for (int k = 0; k < 400 && ng < 5; k++) begin
      #1;
      if (req_ready != 4'b0) begin
        grants[ng] = req_ready;
        $display("grant %0d: ready=%b", ng, req_ready);
        ng++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_count", ng, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("rr_grant%0d", k), grants[k], exp_g[k]);
    wait_done(4'b0001, 1'b0, "rr");
    irq = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
